// File: rtl/terrain_crater.sv
// terrain_crater: carves a filled circular crater into the terrain bitmap.
// Each affected row is read, the disc span is cleared, and the row is written back.
// Optional feature: define TERRAIN_CRATER_COUNT_EN to add the pixels_removed counter.
module terrain_crater #(
    parameter int WIDTH  = 512,
    parameter int ROWS   = 480,
    parameter int R_MAX  = 63,
    parameter int RD_LAT = 1,
    localparam int RW    = $clog2(R_MAX + 1),
    localparam int XW    = $clog2(WIDTH),
    localparam int YW    = $clog2(ROWS) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [XW-1:0]     cx,
    input  logic [YW-1:0]     cy,
    input  logic [RW-1:0]     radius,
    output logic              busy,
    output logic              done,
    output logic [YW-1:0]     read_addr,
    input  logic [WIDTH-1:0]  terrain_out,
    output logic              we,
    output logic [YW-1:0]     write_addr,
    output logic [WIDTH-1:0]  terrain_in
`ifdef TERRAIN_CRATER_COUNT_EN
    ,
    output logic [15:0]       pixels_removed
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_FIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                state_q;
    logic                  busy_q, done_q, we_q;
    logic [YW-1:0]         read_addr_q, write_addr_q;
    logic [WIDTH-1:0]      terrain_in_q;
    logic [WIDTH-1:0]      row_q;
    logic [XW-1:0]         cx_q;
    logic [2*RW-1:0]       r2_q;
    logic signed [RW:0]    dy_q;
    logic [RW-1:0]         hw_q;
    logic [YW-1:0]         y_q, yEnd_q;
    logic [7:0]            waitCnt_q;

    // Start-of-crater geometry: first in-range row, its dy, and the last in-range row.
    logic [YW-1:0]         radExt, yStart_d, yTop, yEnd_d;
    logic                  startBelow;
    logic signed [RW:0]    dyStart_d;
    logic [2*RW-1:0]       r2_d;

    always_comb begin
        radExt     = {{(YW-RW){1'b0}}, radius};
        startBelow = cy < radExt;
        yStart_d   = startBelow ? '0 : cy - radExt;
        dyStart_d  = startBelow ? -$signed({1'b0, cy[RW-1:0]}) : -$signed({1'b0, radius});
        yTop       = cy + radExt;
        yEnd_d     = (yTop > YW'(ROWS - 1)) ? YW'(ROWS - 1) : yTop;
        r2_d       = {{RW{1'b0}}, radius} * {{RW{1'b0}}, radius};
    end

    // Fit test: hw is the exact half-width when hw^2+dy^2 <= r2 < (hw+1)^2+dy^2.
    logic [RW-1:0]         dyAbs;
    logic [RW:0]           hwP1;
    logic [2*RW-1:0]       dySq, hwSq;
    logic [2*RW+1:0]       hwP1Sq, loSum, hiSum, r2Ext;
    logic                  fits, grow;

    always_comb begin
        dyAbs  = RW'(dy_q[RW] ? -dy_q : dy_q);
        hwP1   = (RW+1)'(hw_q) + (RW+1)'(1);
        dySq   = {{RW{1'b0}}, dyAbs} * {{RW{1'b0}}, dyAbs};
        hwSq   = {{RW{1'b0}}, hw_q} * {{RW{1'b0}}, hw_q};
        hwP1Sq = {{(RW+1){1'b0}}, hwP1} * {{(RW+1){1'b0}}, hwP1};
        r2Ext  = {2'b00, r2_q};
        loSum  = {2'b00, hwSq} + {2'b00, dySq};
        hiSum  = hwP1Sq + {2'b00, dySq};
        fits   = (loSum <= r2Ext) && (hiSum > r2Ext);
        grow   = hiSum <= r2Ext;
    end

    // Span mask cx-hw..cx+hw, compared signed so the left edge may go negative and clip.
    logic signed [XW+1:0]  leftEdge, rightEdge;
    logic [WIDTH-1:0]      mask;

    always_comb begin
        leftEdge  = $signed({2'b00, cx_q}) - $signed({{(XW+2-RW){1'b0}}, hw_q});
        rightEdge = $signed({2'b00, cx_q}) + $signed({{(XW+2-RW){1'b0}}, hw_q});
        mask      = '0;
        for (int x = 0; x < WIDTH; x++) begin
            mask[x] = (x >= int'(leftEdge)) && (x <= int'(rightEdge));
        end
    end

`ifdef TERRAIN_CRATER_COUNT_EN
    logic [15:0]           count_q;
    logic [15:0]           rowPop;
    logic [WIDTH-1:0]      rowHit;

    // Number of solid pixels the current span removes from the held row.
    always_comb begin
        rowHit = row_q & mask;
        rowPop = '0;
        for (int x = 0; x < WIDTH; x++) begin
            rowPop = rowPop + 16'(rowHit[x]);
        end
    end
`endif

    // Main sequencer: walks rows top to bottom doing read, fit, write; all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            we_q         <= 1'b0;
            read_addr_q  <= '0;
            write_addr_q <= '0;
            terrain_in_q <= '0;
            row_q        <= '0;
            cx_q         <= '0;
            r2_q         <= '0;
            dy_q         <= '0;
            hw_q         <= '0;
            y_q          <= '0;
            yEnd_q       <= '0;
            waitCnt_q    <= '0;
`ifdef TERRAIN_CRATER_COUNT_EN
            count_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cx_q        <= cx;
                        r2_q        <= r2_d;
                        hw_q        <= '0;
                        dy_q        <= dyStart_d;
                        y_q         <= yStart_d;
                        yEnd_q      <= yEnd_d;
                        read_addr_q <= yStart_d;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ADDR;
`ifdef TERRAIN_CRATER_COUNT_EN
                        count_q     <= '0;
`endif
                    end
                end
                ST_ADDR: begin
                    waitCnt_q <= 8'd1;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (waitCnt_q == 8'(RD_LAT)) begin
                        row_q   <= terrain_out;
                        state_q <= ST_FIT;
                    end else begin
                        waitCnt_q <= waitCnt_q + 8'd1;
                    end
                end
                ST_FIT: begin
                    if (fits) begin
                        we_q         <= 1'b1;
                        write_addr_q <= y_q;
                        terrain_in_q <= row_q & ~mask;
                        state_q      <= ST_WRITE;
                    end else if (grow) begin
                        hw_q <= hw_q + RW'(1);
                    end else begin
                        hw_q <= hw_q - RW'(1);
                    end
                end
                ST_WRITE: begin
                    we_q <= 1'b0;
`ifdef TERRAIN_CRATER_COUNT_EN
                    count_q <= count_q + rowPop;
`endif
                    if (y_q == yEnd_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        y_q         <= y_q + YW'(1);
                        dy_q        <= dy_q + (RW+1)'(1);
                        read_addr_q <= y_q + YW'(1);
                        state_q     <= ST_ADDR;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign we         = we_q;
    assign read_addr  = read_addr_q;
    assign write_addr = write_addr_q;
    assign terrain_in = terrain_in_q;
`ifdef TERRAIN_CRATER_COUNT_EN
    assign pixels_removed = count_q;
`endif

endmodule

// File: tb/tb_terrain_crater.sv
// tb_terrain_crater: drives craters into a behavioural terrain store and compares the
// written rows and final bitmap against a disc model computed directly from the geometry.
module tb_terrain_crater;

    localparam int WIDTH = 512;
    localparam int ROWS  = 480;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [8:0]        cx;
    logic [9:0]        cy;
    logic [5:0]        radius;
    logic              busy;
    logic              done;
    logic [9:0]        read_addr;
    logic [WIDTH-1:0]  terrain_out;
    logic              we;
    logic [9:0]        write_addr;
    logic [WIDTH-1:0]  terrain_in;
`ifdef TERRAIN_CRATER_COUNT_EN
    logic [15:0]       pixels_removed;
`endif

    terrain_crater dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .cx          (cx),
        .cy          (cy),
        .radius      (radius),
        .busy        (busy),
        .done        (done),
        .read_addr   (read_addr),
        .terrain_out (terrain_out),
        .we          (we),
        .write_addr  (write_addr),
        .terrain_in  (terrain_in)
`ifdef TERRAIN_CRATER_COUNT_EN
        ,
        .pixels_removed (pixels_removed)
`endif
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem      [ROWS];
    logic [WIDTH-1:0] modelMem [ROWS];
    int               wrAddrQ[$];
    logic [WIDTH-1:0] wrDataQ[$];
    int               expAddrQ[$];
    logic [WIDTH-1:0] expDataQ[$];
    int               doneCount = 0;
    int               badAddr   = 0;
    int               expRemoved;
    int               checks = 0;
    int               errors = 0;

    // Terrain store with one cycle of read latency, plus a log of every write and done pulse.
    always @(posedge clk) begin
        terrain_out <= (read_addr < ROWS) ? mem[read_addr] : '0;
        if (read_addr >= ROWS) badAddr++;
        if (we) begin
            if (write_addr < ROWS) mem[write_addr] = terrain_in;
            else badAddr++;
            wrAddrQ.push_back(int'(write_addr));
            wrDataQ.push_back(terrain_in);
        end
        if (done) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fillTerrain(input bit randomFill);
        logic [WIDTH-1:0] row;
        for (int r = 0; r < ROWS; r++) begin
            row = '1;
            if (randomFill)
                for (int w = 0; w < WIDTH / 32; w++) row[w*32 +: 32] = $urandom();
            mem[r]      = row;
            modelMem[r] = row;
        end
    endtask

    // Disc model: for each clipped row, the widest hw with hw^2+dy^2 <= r^2 is cleared.
    task automatic modelCrater(input int mcx, input int mcy, input int mr);
        int hw, dy;
        logic [WIDTH-1:0] row;
        expAddrQ.delete();
        expDataQ.delete();
        expRemoved = 0;
        for (int y = mcy - mr; y <= mcy + mr; y++) begin
            if (y < 0 || y >= ROWS) continue;
            dy = y - mcy;
            hw = 0;
            while ((hw + 1) * (hw + 1) + dy * dy <= mr * mr) hw++;
            row = modelMem[y];
            for (int x = mcx - hw; x <= mcx + hw; x++) begin
                if (x < 0 || x >= WIDTH) continue;
                if (row[x]) expRemoved++;
                row[x] = 1'b0;
            end
            modelMem[y] = row;
            expAddrQ.push_back(y);
            expDataQ.push_back(row);
        end
    endtask

    function automatic int terrainMismatches();
        int n = 0;
        for (int r = 0; r < ROWS; r++) if (mem[r] !== modelMem[r]) n++;
        return n;
    endfunction

    task automatic applyStimulus(input int acx, input int acy, input int ar,
                                 input int extraAt, input int extraCx);
        bit sawDone = 0;
        int n;
        modelCrater(acx, acy, ar);
        wrAddrQ.delete();
        wrDataQ.delete();
        doneCount = 0;
        @(negedge clk);
        start  = 1'b1;
        cx     = 9'(acx);
        cy     = 10'(acy);
        radius = 6'(ar);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_rise", busy, 1);
        for (int k = 0; k < 20000; k++) begin
            if (done) begin
                sawDone = 1;
                break;
            end
            if (k == extraAt) begin
                start = 1'b1;
                cx    = 9'(extraCx);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("done_seen", sawDone, 1);
        @(negedge clk);
        checkOutput("done_width", done, 0);
        checkOutput("busy_fall", busy, 0);
        checkOutput("done_pulses", doneCount, 1);
        checkOutput("write_count", wrAddrQ.size(), expAddrQ.size());
        n = (wrAddrQ.size() < expAddrQ.size()) ? wrAddrQ.size() : expAddrQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("wr_addr%0d", i), wrAddrQ[i], expAddrQ[i]);
            checkOutput($sformatf("wr_data%0d", i), wrDataQ[i], expDataQ[i]);
        end
        checkOutput("terrain", terrainMismatches(), 0);
`ifdef TERRAIN_CRATER_COUNT_EN
        checkOutput("pixels_removed", pixels_removed, expRemoved);
`endif
        repeat (4) @(negedge clk);
        checkOutput("idle_quiet", wrAddrQ.size(), expAddrQ.size());
        checkOutput("bad_addr", badAddr, 0);
    endtask

    // Top-level sequence: reset checks, directed craters, randomized craters, mid-run reset.
    initial begin
        logic [WIDTH-1:0] expRow;
        bit sawWe;
        reset_n = 1'b0;
        start   = 1'b0;
        cx      = '0;
        cy      = '0;
        radius  = '0;
        fillTerrain(0);
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_we", we, 0);
        checkOutput("rst_raddr", read_addr, 0);
        checkOutput("rst_waddr", write_addr, 0);
        checkOutput("rst_tin", terrain_in, 0);
`ifdef TERRAIN_CRATER_COUNT_EN
        checkOutput("rst_count", pixels_removed, 0);
`endif
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single pixel crater.
        fillTerrain(0);
        applyStimulus(10, 5, 0, -1, 0);
        checkOutput("s1_writes", wrAddrQ.size(), 1);
        checkOutput("s1_bit10", mem[5][10], 0);
        checkOutput("s1_bit9", mem[5][9], 1);

        // Radius 2 on full terrain.
        fillTerrain(0);
        applyStimulus(100, 50, 2, -1, 0);
        expRow = '1;
        for (int x = 98; x <= 102; x++) expRow[x] = 1'b0;
        checkOutput("s2_row50", mem[50], expRow);
        checkOutput("s2_writes", wrAddrQ.size(), 5);
`ifdef TERRAIN_CRATER_COUNT_EN
        checkOutput("s7_count13", pixels_removed, 13);
        applyStimulus(100, 50, 2, -1, 0);
        checkOutput("s7_count0", pixels_removed, 0);
`endif

        // Clipping at the top-left and bottom-right corners.
        fillTerrain(1);
        applyStimulus(0, 0, 3, -1, 0);
        checkOutput("s3_writes", wrAddrQ.size(), 4);
        applyStimulus(511, 479, 1, -1, 0);
        checkOutput("s4_writes", wrAddrQ.size(), 2);

        // Second start while busy must be ignored.
        applyStimulus(200, 100, 4, 3, 300);

        // Randomized craters, including edge-hugging centres and full radius.
        for (int t = 0; t < 8; t++) begin
            int rcx, rcy, rr;
            rcx = (t == 0) ? 511 : int'($urandom_range(0, WIDTH - 1));
            rcy = (t == 1) ? 0 : int'($urandom_range(0, ROWS - 1));
            rr  = (t == 2) ? 63 : int'($urandom_range(0, 63));
            applyStimulus(rcx, rcy, rr, -1, 0);
        end

        // Reset during the wait for the second row's data.
        fillTerrain(0);
        modelCrater(100, 50, 2);
        for (int y = 49; y <= 52; y++) modelMem[y] = '1;
        wrAddrQ.delete();
        wrDataQ.delete();
        @(negedge clk);
        start  = 1'b1;
        cx     = 9'd100;
        cy     = 10'd50;
        radius = 6'd2;
        @(negedge clk);
        start = 1'b0;
        sawWe = 0;
        for (int k = 0; k < 200; k++) begin
            if (we) begin
                sawWe = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("s6_first_we", sawWe, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("s6_busy", busy, 0);
        checkOutput("s6_we", we, 0);
        checkOutput("s6_done", done, 0);
        checkOutput("s6_raddr", read_addr, 0);
        checkOutput("s6_waddr", write_addr, 0);
        checkOutput("s6_tin", terrain_in, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("s6_writes", wrAddrQ.size(), 1);
        checkOutput("s6_row48", mem[48], modelMem[48]);
        checkOutput("s6_terrain", terrainMismatches(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
